// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares the usb_uart byte input (uart_in_data/valid/ready) between two
//   byte-stream sources. A grant is line-locked: the owner keeps the pipe
//   until it sends EOL_CHAR, reaches MAX_BURST bytes, or stays idle for
//   IDLE_TIMEOUT cycles. Ties in IDLE are resolved round robin against the
//   last owner. The data path is a purely combinational pass-through while
//   granted, so throughput is one byte per cycle.
//
// Ports (all in the clk_48mhz domain):
//   clk_48mhz   system clock
//   reset       asynchronous active-high reset
//   req0_*      source 0 valid/ready byte stream (data, valid in; ready out)
//   req1_*      source 1 valid/ready byte stream (data, valid in; ready out)
//   out_data    byte to usb_uart uart_in_data
//   out_valid   to uart_in_valid
//   out_ready   from uart_in_ready
//   grant       one-hot current owner, 2'b00 when idle
//   busy        high while either source holds a grant
module uart_tx_arbiter #(
    parameter logic [7:0] EOL_CHAR     = 8'h0A,
    parameter int         MAX_BURST    = 64,
    parameter int         IDLE_TIMEOUT = 4800
) (
    input  logic       clk_48mhz,
    input  logic       reset,
    input  logic [7:0] req0_data,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req1_data,
    input  logic       req1_valid,
    output logic       req1_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] grant,
    output logic       busy
);

    localparam int BURST_W = $clog2(MAX_BURST + 1);
    localparam int IDLE_W  = $clog2(IDLE_TIMEOUT + 1);

    // Comparing against N-1 on the current count is the same test as
    // count+1 == N, without needing the wider sum.
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
    localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(IDLE_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic [BURST_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;

    logic                own1;       // current owner is source 1
    logic                sel_valid;
    logic [7:0]          sel_data;
    logic                release_now;

    // State register and counters
    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;     // makes source 0 win the first tie
            burst_cnt_q  <= '0;
            idle_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
        end
    end

    // Next state, counters and pass-through outputs
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        burst_cnt_d  = burst_cnt_q;
        idle_cnt_d   = idle_cnt_q;
        own1         = 1'b0;
        sel_valid    = 1'b0;
        sel_data     = 8'h00;
        release_now  = 1'b0;
        out_data     = 8'h00;
        out_valid    = 1'b0;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        grant        = 2'b00;
        busy         = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // No transfer can happen here; this cycle only picks the owner.
                if (req0_valid && req1_valid) begin
                    state_d = last_grant_q ? ST_GRANT0 : ST_GRANT1;
                end else if (req0_valid) begin
                    state_d = ST_GRANT0;
                end else if (req1_valid) begin
                    state_d = ST_GRANT1;
                end
            end

            ST_GRANT0, ST_GRANT1: begin
                own1      = (state_q == ST_GRANT1);
                sel_valid = own1 ? req1_valid : req0_valid;
                sel_data  = own1 ? req1_data  : req0_data;

                out_data   = sel_data;
                out_valid  = sel_valid;
                req0_ready = !own1 && out_ready;
                req1_ready = own1 && out_ready;
                grant      = own1 ? 2'b10 : 2'b01;
                busy       = 1'b1;

                if (sel_valid && out_ready) begin
                    idle_cnt_d  = '0;
                    burst_cnt_d = burst_cnt_q + 1'b1;
                    release_now = (sel_data == EOL_CHAR) || (burst_cnt_q == BURST_LAST);
                end else if (!sel_valid) begin
                    idle_cnt_d  = idle_cnt_q + 1'b1;
                    release_now = (idle_cnt_q == IDLE_LAST);
                end
                // valid with the sink stalled: both counters hold, never release

                if (release_now) begin
                    state_d      = ST_IDLE;
                    last_grant_d = own1;
                    burst_cnt_d  = '0;
                    idle_cnt_d   = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Structural invariants of the outputs
    a_grant_onehot: assert property (@(posedge clk_48mhz) disable iff (reset)
        $onehot0(grant));
    a_idle_quiet: assert property (@(posedge clk_48mhz) disable iff (reset)
        (grant == 2'b00) |-> (!out_valid && !req0_ready && !req1_ready));
    a_single_ready: assert property (@(posedge clk_48mhz) disable iff (reset)
        !(req0_ready && req1_ready));

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a vector table for the basic handshakes, hand
// sequences for burst limit, idle timeout, long stalls and reset mid-burst,
// then randomized traffic checked every cycle against a rule-level model of
// ownership plus an end-to-end byte scoreboard per source.
module tb_uart_tx_arbiter;

    localparam logic [7:0] EOL  = 8'h0A;
    localparam int         MAXB = 64;
    localparam int         TMO  = 4800;

    logic       clk_48mhz = 1'b0;
    logic       reset     = 1'b1;
    logic [7:0] req0_data = 8'h00;
    logic       req0_valid = 1'b0;
    logic       req0_ready;
    logic [7:0] req1_data = 8'h00;
    logic       req1_valid = 1'b0;
    logic       req1_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [1:0] grant;
    logic       busy;

    always #5 clk_48mhz = ~clk_48mhz;

    uart_tx_arbiter #(
        .EOL_CHAR    (EOL),
        .MAX_BURST   (MAXB),
        .IDLE_TIMEOUT(TMO)
    ) dut (
        .clk_48mhz (clk_48mhz),
        .reset     (reset),
        .req0_data (req0_data),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req1_data (req1_data),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .grant     (grant),
        .busy      (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // {grant, busy, out_valid, out_data, req0_ready, req1_ready}
    function automatic logic [13:0] outs();
        return {grant, busy, out_valid, out_data, req0_ready, req1_ready};
    endfunction

    function automatic logic [13:0] e(input logic [1:0] g, input logic ov, input logic [7:0] od,
                                      input logic r0, input logic r1);
        return {g, |g, ov, od, r0, r1};
    endfunction

    typedef struct packed {
        logic        rst;
        logic        v0;
        logic [7:0]  d0;
        logic        v1;
        logic [7:0]  d1;
        logic        ordy;
        logic [13:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic v0, input logic [7:0] d0,
                                input logic v1, input logic [7:0] d1, input logic ordy,
                                input logic [13:0] exp);
        vec_t r;
        r.rst = rst; r.v0 = v0; r.d0 = d0; r.v1 = v1; r.d1 = d1; r.ordy = ordy; r.exp = exp;
        return r;
    endfunction

    vec_t tbl[$];

    // ---------------- scoreboard / model state ----------------
    typedef struct {
        int         src;
        logic [7:0] data;
        int         cyc;
    } xfer_t;

    xfer_t      xlog[$];
    logic [7:0] q0[$], q1[$];
    logic [7:0] sent0[$], sent1[$], sink0[$], sink1[$];
    bit         en0 = 0, en1 = 0, hs0 = 0, hs1 = 0;
    int         cyc = 0;

    // Ownership model: who should own the pipe, how many bytes it moved in
    // this grant, and how long it has been silent.
    int m_owner = -1;
    int m_last  = 1;
    int m_bytes = 0;
    int m_quiet = 0;

    task automatic model_check();
        logic [13:0] exp;
        logic        sv;
        logic [7:0]  sd;
        bit          rel;
        rel = 0;
        if (reset) begin
            exp = '0;
            m_owner = -1; m_last = 1; m_bytes = 0; m_quiet = 0;
        end else if (m_owner < 0) begin
            exp = '0;
            if (req0_valid && req1_valid) m_owner = (m_last == 0) ? 1 : 0;
            else if (req0_valid)          m_owner = 0;
            else if (req1_valid)          m_owner = 1;
        end else begin
            sv = (m_owner == 1) ? req1_valid : req0_valid;
            sd = (m_owner == 1) ? req1_data  : req0_data;
            exp = e((m_owner == 1) ? 2'b10 : 2'b01, sv, sd,
                    (m_owner == 0) && out_ready, (m_owner == 1) && out_ready);
            if (sv && out_ready) begin
                m_bytes++;
                m_quiet = 0;
                if (sd == EOL || m_bytes == MAXB) rel = 1;
            end else if (!sv) begin
                m_quiet++;
                if (m_quiet == TMO) rel = 1;
            end
            if (rel) begin
                m_last = m_owner; m_owner = -1; m_bytes = 0; m_quiet = 0;
            end
        end
        check($sformatf("cycle%0d_outputs", cyc), outs(), exp);
    endtask

    task automatic drive();
        req0_valid = (req0_valid && !hs0) || (en0 && q0.size() > 0);
        req0_data  = (req0_valid && q0.size() > 0) ? q0[0] : 8'h00;
        req1_valid = (req1_valid && !hs1) || (en1 && q1.size() > 0);
        req1_data  = (req1_valid && q1.size() > 0) ? q1[0] : 8'h00;
    endtask

    task automatic cycle();
        @(negedge clk_48mhz);
        model_check();
        hs0 = req0_valid && req0_ready;
        hs1 = req1_valid && req1_ready;
        if (out_valid && out_ready) begin
            xlog.push_back('{src: (grant[1] ? 1 : 0), data: out_data, cyc: cyc});
            if (grant[1]) sink1.push_back(out_data);
            else          sink0.push_back(out_data);
        end
        cyc++;
        @(posedge clk_48mhz);
        #1;
        if (hs0) void'(q0.pop_front());
        if (hs1) void'(q1.pop_front());
        drive();
        hs0 = 0;
        hs1 = 0;
    endtask

    task automatic push0(input logic [7:0] b);
        q0.push_back(b);
        sent0.push_back(b);
    endtask

    task automatic push1(input logic [7:0] b);
        q1.push_back(b);
        sent1.push_back(b);
    endtask

    task automatic apply_reset();
        en0 = 0;
        en1 = 0;
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic wait_xlog(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (xlog.size() < n && k < budget) begin
            cycle();
            k++;
        end
        check({name, "_within_budget"}, 32'(xlog.size() >= n), 32'd1);
    endtask

    task automatic gen_line(input int src);
        int         len;
        bit         long_line;
        logic [7:0] b;
        long_line = ($urandom % 10) == 0;
        len = long_line ? 70 : $urandom_range(1, 12);
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            if (long_line && b == EOL) b = 8'h20;
            if (i == len - 1 && !long_line && ($urandom % 10) < 7) b = EOL;
            if (src == 0) push0(b);
            else          push1(b);
        end
    endtask

    function automatic bit same_q(input logic [7:0] a[$], input logic [7:0] b[$]);
        if (a.size() != b.size()) return 0;
        foreach (a[i]) if (a[i] !== b[i]) return 0;
        return 1;
    endfunction

    initial begin
        int b;

        // "AB\n" from source 0 alone, then a tie from reset with "X\n" each
        tbl.push_back(mk(0, 1, 8'h41, 0, 8'h00, 1, e(2'b00, 0, 8'h00, 0, 0)));
        tbl.push_back(mk(0, 1, 8'h41, 0, 8'h00, 1, e(2'b01, 1, 8'h41, 1, 0)));
        tbl.push_back(mk(0, 1, 8'h42, 0, 8'h00, 1, e(2'b01, 1, 8'h42, 1, 0)));
        tbl.push_back(mk(0, 1, 8'h0A, 0, 8'h00, 1, e(2'b01, 1, 8'h0A, 1, 0)));
        tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 1, e(2'b00, 0, 8'h00, 0, 0)));
        tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 1, e(2'b00, 0, 8'h00, 0, 0)));
        tbl.push_back(mk(1, 1, 8'h58, 1, 8'h58, 1, e(2'b00, 0, 8'h00, 0, 0)));
        tbl.push_back(mk(0, 1, 8'h58, 1, 8'h58, 1, e(2'b00, 0, 8'h00, 0, 0)));
        tbl.push_back(mk(0, 1, 8'h58, 1, 8'h58, 1, e(2'b01, 1, 8'h58, 1, 0)));
        tbl.push_back(mk(0, 1, 8'h0A, 1, 8'h58, 1, e(2'b01, 1, 8'h0A, 1, 0)));
        tbl.push_back(mk(0, 0, 8'h00, 1, 8'h58, 1, e(2'b00, 0, 8'h00, 0, 0)));
        tbl.push_back(mk(0, 0, 8'h00, 1, 8'h58, 1, e(2'b10, 1, 8'h58, 0, 1)));
        tbl.push_back(mk(0, 0, 8'h00, 1, 8'h0A, 0, e(2'b10, 1, 8'h0A, 0, 0)));
        tbl.push_back(mk(0, 0, 8'h00, 1, 8'h0A, 1, e(2'b10, 1, 8'h0A, 0, 1)));
        tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 1, e(2'b00, 0, 8'h00, 0, 0)));

        #2;
        check("reset_outputs", 32'(outs()), 32'd0);
        @(posedge clk_48mhz);
        #1;
        reset = 1'b0;

        foreach (tbl[i]) begin
            reset      = tbl[i].rst;
            req0_valid = tbl[i].v0;
            req0_data  = tbl[i].d0;
            req1_valid = tbl[i].v1;
            req1_data  = tbl[i].d1;
            out_ready  = tbl[i].ordy;
            @(negedge clk_48mhz);
            check($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
            @(posedge clk_48mhz);
            #1;
        end
        req0_valid = 0;
        req1_valid = 0;
        reset      = 0;

        // Burst limit: source 1 streams 100 bytes, source 0 waits with "Z\n"
        apply_reset();
        out_ready = 1;
        for (int i = 0; i < 100; i++) push1(8'h30 + 8'(i % 40));
        en1 = 1;
        drive();
        b = xlog.size();
        cycle();
        cycle();
        push0(8'h5A);
        push0(EOL);
        en0 = 1;
        wait_xlog(b + 102, 400, "burst");
        if (xlog.size() >= b + 102) begin
            check("burst_last_of_first_grant", 32'(xlog[b + 63].src), 32'd1);
            check("burst_src0_after_limit", 32'(xlog[b + 64].src), 32'd0);
            check("burst_one_bubble", 32'(xlog[b + 64].cyc - xlog[b + 63].cyc), 32'd2);
            check("burst_src1_regains", {31'd0, xlog[b + 66].src[0]}, 32'd1);
        end

        // Idle timeout: source 0 sends one byte then goes quiet, source 1 waits
        apply_reset();
        out_ready = 1;
        push0(8'h41);
        push1(8'h61);
        en0 = 1;
        en1 = 1;
        drive();
        b = xlog.size();
        wait_xlog(b + 2, 6000, "timeout");
        if (xlog.size() >= b + 2) begin
            check("timeout_first", {xlog[b].src[7:0], xlog[b].data}, {8'd0, 8'h41});
            check("timeout_second", {xlog[b + 1].src[7:0], xlog[b + 1].data}, {8'd1, 8'h61});
            check("timeout_latency", 32'(xlog[b + 1].cyc - xlog[b].cyc), 32'd4802);
        end

        // Long sink stall: no release, no transfer, then completion
        apply_reset();
        out_ready = 0;
        push0(8'h55);
        push0(EOL);
        en0 = 1;
        drive();
        b = xlog.size();
        for (int i = 0; i < 10001; i++) cycle();
        check("stall_no_transfer", 32'(xlog.size()), 32'(b));
        check("stall_grant_held", {30'd0, grant}, 32'd1);
        check("stall_data", {24'd0, out_data}, 32'h55);
        out_ready = 1;
        wait_xlog(b + 2, 10, "stall_resume");
        if (xlog.size() >= b + 2) begin
            check("stall_resume_bytes", {xlog[b].data, xlog[b + 1].data}, {16'd0, 8'h55, EOL});
        end

        // Reset in the middle of a 5-byte burst
        apply_reset();
        out_ready = 1;
        push0(8'h01); push0(8'h02); push0(8'h03); push0(8'h04); push0(EOL);
        en0 = 1;
        drive();
        b = xlog.size();
        wait_xlog(b + 2, 10, "midrst_first_two");
        reset = 1'b1;
        #1;
        check("midrst_async_outputs", 32'(outs()), 32'd0);
        push1(8'h71);
        push1(EOL);
        en1 = 1;
        drive();
        cycle();
        reset = 1'b0;
        wait_xlog(b + 7, 40, "midrst_rest");
        if (xlog.size() >= b + 7) begin
            check("midrst_byte3_src0_first", {xlog[b + 2].src[7:0], xlog[b + 2].data}, {8'd0, 8'h03});
        end

        // Randomized traffic
        apply_reset();
        for (int i = 0; i < 4000; i++) begin
            en0 = ($urandom % 4) != 0;
            en1 = ($urandom % 4) != 0;
            out_ready = ($urandom % 4) != 0;
            if (q0.size() == 0 && ($urandom % 6) == 0) gen_line(0);
            if (q1.size() == 0 && ($urandom % 6) == 0) gen_line(1);
            drive();
            cycle();
        end
        en0 = 1;
        en1 = 1;
        out_ready = 1;
        drive();
        begin
            int k;
            k = 0;
            while ((q0.size() > 0 || q1.size() > 0) && k < 12000) begin
                cycle();
                k++;
            end
            check("drain_within_budget", 32'(q0.size() + q1.size()), 32'd0);
        end
        cycle();

        check("integrity_src0", 32'(same_q(sink0, sent0)), 32'd1);
        check("integrity_src1", 32'(same_q(sink1, sent1)), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the usb_uart byte input pipeline (uart_in_data/valid/ready) between two byte-stream requesters, e.g. the SoC serial path and a debug/status source. Grants are line-locked: a granted source keeps the pipe until it sends an end-of-line byte, hits a burst limit, or goes idle. This keeps lines from the two sources from interleaving. Sits in the 48 MHz domain between the requesters and usb_uart.

Parameters:
EOL_CHAR, 8'h0A, byte value that ends a granted burst
MAX_BURST, 64, maximum bytes per grant (>=1)
IDLE_TIMEOUT, 4800, cycles without source valid before a grant is revoked (100 us at 48 MHz, >=1)

Ports:
clk_48mhz  in  1  system clock
reset  in  1  asynchronous, active-high reset
req0_data  in  8  source 0 byte
req0_valid  in  1  source 0 byte valid
req0_ready  out  1  source 0 byte accepted
req1_data  in  8  source 1 byte
req1_valid  in  1  source 1 byte valid
req1_ready  out  1  source 1 byte accepted
out_data  out  8  byte to usb_uart uart_in_data
out_valid  out  1  to uart_in_valid
out_ready  in  1  from uart_in_ready
grant  out  2  one-hot current owner, 2'b00 when idle
busy  out  1  high in any GRANT state

Behaviour:
- Handshake: a transfer occurs on a cycle with valid & ready. Sources hold data stable while valid & !ready.
- Reset (async): state IDLE, grant=00, busy=0, out_valid=0, out_data=0, req0_ready=req1_ready=0, last_grant=1 (source 0 wins the first tie), burst_cnt=0, idle_cnt=0.
- FSM states: IDLE, GRANT0, GRANT1.
- IDLE:
  - out_valid=0, both readys 0; no transfer ever occurs in IDLE.
  - If exactly one reqN_valid is high, next state is GRANTN.
  - If both are high, grant the source != last_grant (round robin).
  - If neither is high, stay in IDLE.
  - Arbitration latency: the first byte can transfer in the cycle after the request is seen in IDLE.
- GRANTN (combinational pass-through, zero added latency):
  - out_data=reqN_data, out_valid=reqN_valid, reqN_ready=out_ready.
  - The non-granted ready is held 0.
  - grant=one-hot N, busy=1.
- On a transfer in GRANTN:
  - idle_cnt<=0, burst_cnt<=burst_cnt+1.
  - Release if out_data==EOL_CHAR or burst_cnt+1==MAX_BURST.
- Cycle in GRANTN with reqN_valid=0:
  - idle_cnt<=idle_cnt+1.
  - Release when idle_cnt==IDLE_TIMEOUT-1, i.e. after IDLE_TIMEOUT consecutive non-valid cycles.
- Cycle with reqN_valid=1 & out_ready=0 (sink stall): idle_cnt holds. Stalls never cause a release.
- Release: next state IDLE; last_grant<=N; burst_cnt<=0; idle_cnt<=0. A timeout release with zero bytes sent still updates last_grant.
- Back-to-back grants always have exactly one IDLE bubble cycle between them.
- Simultaneous EOL and MAX_BURST on one transfer: a single release.
- Counter widths: burst_cnt is clog2(MAX_BURST+1) bits; idle_cnt is clog2(IDLE_TIMEOUT+1) bits. Neither counter wraps, because release occurs before overflow.
- Reset mid-burst:
  - All outputs return to reset values immediately.
  - A byte presented but not handshaken is not consumed (its ready is 0).
  - out_valid may fall without a transfer only on reset.
- Throughput: one byte per cycle while the sink is ready within a grant.

Test Plan:
- Source 0 alone sends "AB\n" (0x41,0x42,0x0A), out_ready=1 -> grant=01 one cycle after the first valid; 3 transfers on consecutive cycles; IDLE the cycle after 0x0A; grant=00.
- Both sources valid from reset, each sending "X\n" -> source 0 served first (X,0x0A), one bubble cycle, then source 1 (X,0x0A). req1_ready=0 throughout source 0's grant.
- Source 1 streams 100 bytes with no 0x0A, source 0 waiting -> release after byte 64; source 0 granted after one bubble; source 1 regains the grant after source 0 finishes.
- Source 0 sends 0x41 then drops valid, source 1 waiting -> release after 4800 idle cycles; source 1 granted on cycle 4802 after the last transfer.
- Granted source valid with out_ready=0 for 10000 cycles -> no release, no transfer, out_data stable; the transfer completes when out_ready rises.
- reset asserted mid-burst after 2 of 5 bytes -> outputs go to reset values immediately; after deassert, the arbiter re-arbitrates with source 0 priority; byte 3 is transferred exactly once.
